// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the fetch stage
// Contents:
//   word_t       32-bit machine word
//   pcsel_t      next-PC source selected by decode
//   br_offset()  word-offset branch immediate -> byte offset
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_JUMP   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JR     = 2'b10,
    PC_SEQ    = 2'b11
  } pcsel_t;

  // Sign-extend a 16-bit word offset and scale it to bytes.
  function automatic word_t br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction cache request/response bundle
// Signals:
//   iREN      fetch -> icache  read enable
//   imemaddr  fetch -> icache  fetch address
//   ihit      icache -> fetch  imemload is valid for imemaddr this cycle
//   imemload  icache -> fetch  instruction word
// Modports: master (fetch side), slave (icache side).
interface fetch_stage_if import cpu_types_pkg::*; ();

  logic  iREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport master (output iREN, output imemaddr, input ihit, input imemload);
  modport slave  (input iREN, input imemaddr, output ihit, output imemload);

endinterface

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - redirect decision and control-flow target select
// Ports:
//   pcsel_i         next-PC source from decode
//   branch_taken_i  branch condition resolved true
//   valid_i         IF/ID holds a live instruction
//   stall_i         hazard stall
//   npc_i           IF/ID PC+4 of the instruction in decode
//   br_imm_i        branch offset in words
//   jaddr_i         jump target field
//   jr_addr_i       register target for jr
//   redirect_o      fetch must be steered to target_o
//   target_o        redirect address
module pc_next_calc import cpu_types_pkg::*; (
  input  pcsel_t      pcsel_i,
  input  logic        branch_taken_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  word_t       npc_i,
  input  logic [15:0] br_imm_i,
  input  logic [25:0] jaddr_i,
  input  word_t       jr_addr_i,
  output logic        redirect_o,
  output word_t       target_o
);

  always_comb begin
    redirect_o = 1'b0;
    target_o   = npc_i;
    case (pcsel_i)
      PC_JUMP: begin
        redirect_o = 1'b1;
        target_o   = {npc_i[31:28], jaddr_i, 2'b00};
      end
      PC_BRANCH: begin
        redirect_o = branch_taken_i;
        target_o   = npc_i + br_offset(br_imm_i);
      end
      PC_JR: begin
        redirect_o = 1'b1;
        target_o   = jr_addr_i;
      end
      default: begin
        redirect_o = 1'b0;
        target_o   = npc_i;
      end
    endcase
    // A stalled or empty decode slot never steers fetch.
    redirect_o = redirect_o & valid_i & ~stall_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID latch
// Optional feature: FETCH_SKID_EN adds a one-entry skid buffer that keeps an
// icache hit arriving during a stall instead of refetching it.
// Parameters:
//   PC_INIT       PC value loaded on reset
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   imem          icache bundle (master side)
//   stall         hazard stall: hold IF/ID and PC
//   PCSel         decode next-PC source (00 jump, 01 branch, 10 jr, 11 seq)
//   branch_taken  branch condition true
//   br_imm        branch word offset
//   jaddr         jump target field
//   jr_addr       jr register target
//   halt          HALT decoded in ID
//   instr_o       IF/ID instruction
//   npc_o         IF/ID PC+4
//   valid_o       IF/ID holds a live instruction
module fetch_stage import cpu_types_pkg::*; #(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic [1:0]    PCSel,
  input  logic          branch_taken,
  input  logic [15:0]   br_imm,
  input  logic [25:0]   jaddr,
  input  word_t         jr_addr,
  input  logic          halt,
  output word_t         instr_o,
  output word_t         npc_o,
  output logic          valid_o
);

  word_t pc_q, pc_d;
  word_t instr_q, instr_d;
  word_t npc_q, npc_d;
  logic  valid_q, valid_d;
  logic  halted_q, halted_d;

`ifdef FETCH_SKID_EN
  logic  skid_valid_q, skid_valid_d;
  word_t skid_instr_q, skid_instr_d;
  word_t skid_npc_q, skid_npc_d;
`endif

  logic  redirect;
  word_t target;
  word_t pc_plus4;

  assign pc_plus4      = pc_q + 32'd4;
  assign imem.iREN     = ~halted_q;
  assign imem.imemaddr = pc_q;
  assign instr_o       = instr_q;
  assign npc_o         = npc_q;
  assign valid_o       = valid_q;

  pc_next_calc u_pc_next_calc (
    .pcsel_i        (pcsel_t'(PCSel)),
    .branch_taken_i (branch_taken),
    .valid_i        (valid_q),
    .stall_i        (stall),
    .npc_i          (npc_q),
    .br_imm_i       (br_imm),
    .jaddr_i        (jaddr),
    .jr_addr_i      (jr_addr),
    .redirect_o     (redirect),
    .target_o       (target)
  );

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    valid_d  = valid_q;
    halted_d = halted_q | (halt & valid_q & ~stall);
`ifdef FETCH_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_npc_d   = skid_npc_q;
`endif

    if (halted_q) begin
      valid_d = 1'b0;
    end else if (stall) begin
`ifdef FETCH_SKID_EN
      // Keep one hit that lands while decode is stalled and move the PC on.
      if (imem.ihit && !skid_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem.imemload;
        skid_npc_d   = pc_plus4;
        pc_d         = pc_plus4;
      end
`endif
    end else if (redirect) begin
      pc_d    = target;
      instr_d = '0;
      npc_d   = '0;
      valid_d = 1'b0;
`ifdef FETCH_SKID_EN
      skid_valid_d = 1'b0;
`endif
`ifdef FETCH_SKID_EN
    end else if (skid_valid_q) begin
      // Drain the buffered word; the PC already points past it, so this
      // cycle's icache response is ignored and re-requested next cycle.
      instr_d      = skid_instr_q;
      npc_d        = skid_npc_q;
      valid_d      = 1'b1;
      skid_valid_d = 1'b0;
`endif
    end else if (imem.ihit) begin
      pc_d    = pc_plus4;
      instr_d = imem.imemload;
      npc_d   = pc_plus4;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q     <= PC_INIT;
      instr_q  <= '0;
      npc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_npc_q   <= '0;
`endif
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
`ifdef FETCH_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_npc_q   <= skid_npc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        stall;
  logic [1:0]  PCSel;
  logic        branch_taken;
  logic [15:0] br_imm;
  logic [25:0] jaddr;
  word_t       jr_addr;
  logic        halt;
  word_t       instr_o;
  word_t       npc_o;
  logic        valid_o;

  int total = 0;
  int bad   = 0;

  fetch_stage_if imem_if ();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .imem         (imem_if.master),
    .stall        (stall),
    .PCSel        (PCSel),
    .branch_taken (branch_taken),
    .br_imm       (br_imm),
    .jaddr        (jaddr),
    .jr_addr      (jr_addr),
    .halt         (halt),
    .instr_o      (instr_o),
    .npc_o        (npc_o),
    .valid_o      (valid_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then back to the falling edge for sampling/driving.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST              = 1'b1;
    stall            = 1'b0;
    PCSel            = 2'b11;
    branch_taken     = 1'b0;
    br_imm           = 16'h0000;
    jaddr            = 26'h0;
    jr_addr          = 32'h0;
    halt             = 1'b0;
    imem_if.ihit     = 1'b0;
    imem_if.imemload = 32'h0;

    // Reset state
    step();
    step();
    check("rst_pc",    imem_if.imemaddr, 32'h0);
    check("rst_valid", {31'b0, valid_o}, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_npc",   npc_o, 32'h0);
    check("rst_iren",  {31'b0, imem_if.iREN}, 32'h1);

    // Sequential fetch
    RST = 1'b0;
    imem_if.ihit     = 1'b1;
    imem_if.imemload = 32'h2001_0005;
    check("seq_pc0", imem_if.imemaddr, 32'h0);
    step();
    check("seq_pc4",   imem_if.imemaddr, 32'h4);
    check("seq_instr", instr_o, 32'h2001_0005);
    check("seq_npc",   npc_o, 32'h4);
    check("seq_valid", {31'b0, valid_o}, 32'h1);
    step();
    check("seq_pc8", imem_if.imemaddr, 32'h8);
    step();
    step();
    check("br_pre_npc", npc_o, 32'h10);

    // Taken branch back two words from npc 0x10
    PCSel = 2'b01; branch_taken = 1'b1; br_imm = 16'hFFFE;
    step();
    check("br_pc",    imem_if.imemaddr, 32'h8);
    check("br_valid", {31'b0, valid_o}, 32'h0);
    check("br_instr", instr_o, 32'h0);
    check("br_npc",   npc_o, 32'h0);
    PCSel = 2'b11; branch_taken = 1'b0;

    // Jump held off by a two-cycle stall
    imem_if.imemload = 32'h0800_0040;
    step();
    check("jmp_pre_pc", imem_if.imemaddr, 32'hC);
    PCSel = 2'b00; jaddr = 26'h0000040; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc",    imem_if.imemaddr, 32'hC);
      check("stall_npc",   npc_o, 32'hC);
      check("stall_instr", instr_o, 32'h0800_0040);
      check("stall_valid", {31'b0, valid_o}, 32'h1);
    end
    stall = 1'b0;
    step();
    check("jmp_pc",    imem_if.imemaddr, 32'h100);
    check("jmp_valid", {31'b0, valid_o}, 32'h0);

    // Jump to 0x20, then a three-cycle icache miss
    PCSel = 2'b11;
    step();
    check("pre_jr_npc", npc_o, 32'h104);
    PCSel = 2'b00; jaddr = 26'h0000008;
    step();
    check("miss_pc_entry", imem_if.imemaddr, 32'h20);
    PCSel = 2'b11; imem_if.ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("miss_valid", {31'b0, valid_o}, 32'h0);
      check("miss_pc",    imem_if.imemaddr, 32'h20);
    end

    // jr through a register target
    imem_if.ihit = 1'b1;
    step();
    PCSel = 2'b10; jr_addr = 32'h0000_0200;
    step();
    check("jr_pc", imem_if.imemaddr, 32'h200);
    PCSel = 2'b11;

    // Halt
    step();
    check("halt_pre_valid", {31'b0, valid_o}, 32'h1);
    check("halt_pre_iren",  {31'b0, imem_if.iREN}, 32'h1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_iren", {31'b0, imem_if.iREN}, 32'h0);
    check("halt_pc",   imem_if.imemaddr, 32'h208);
    for (int i = 0; i < 10; i++) begin
      step();
      check("halted_pc",    imem_if.imemaddr, 32'h208);
      check("halted_valid", {31'b0, valid_o}, 32'h0);
    end

    // Asynchronous reset mid-stall while halted
    stall = 1'b1;
    #2 RST = 1'b1;
    #1;
    check("arst_pc",    imem_if.imemaddr, 32'h0);
    check("arst_iren",  {31'b0, imem_if.iREN}, 32'h1);
    check("arst_valid", {31'b0, valid_o}, 32'h0);
    @(negedge CLK);
    RST = 1'b0; stall = 1'b0;
    imem_if.imemload = 32'h1111_1111;
    step();
    check("post_rst_npc",   npc_o, 32'h4);
    check("post_rst_instr", instr_o, 32'h1111_1111);

    // Hit during a one-cycle stall
    stall = 1'b1; imem_if.imemload = 32'hAAAA_0001;
    step();
    check("skid_hold_npc",   npc_o, 32'h4);
    check("skid_hold_instr", instr_o, 32'h1111_1111);
`ifdef FETCH_SKID_EN
    check("skid_pc_adv", imem_if.imemaddr, 32'h8);
`else
    check("noskid_pc_hold", imem_if.imemaddr, 32'h4);
`endif
    stall = 1'b0; imem_if.imemload = 32'hBBBB_0002;
    step();
`ifdef FETCH_SKID_EN
    check("skid_instr", instr_o, 32'hAAAA_0001);
    check("skid_npc",   npc_o, 32'h8);
    check("skid_pc",    imem_if.imemaddr, 32'h8);
`else
    check("noskid_instr", instr_o, 32'hBBBB_0002);
    check("noskid_npc",   npc_o, 32'h8);
    check("noskid_pc",    imem_if.imemaddr, 32'h8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port ihit  input  1  icache returned imemload for imemaddr this cycle.
REQ-005 SHALL have port imemload  input  32  instruction word from icache.
REQ-006 SHALL have port iREN  output  1  icache read enable.
REQ-007 SHALL have port imemaddr  output  32  fetch address, equal to the PC register.
REQ-008 SHALL have port stall  input  1  hazard stall; hold the IF/ID latch and the PC.
REQ-009 SHALL have port PCSel  input  2  from decode: 00 jump, 01 branch, 10 jr, 11 sequential.
REQ-010 SHALL have port branch_taken  input  1  branch condition resolved true (meaningful only with PCSel=01).
REQ-011 SHALL have port br_imm  input  16  branch offset, in words.
REQ-012 SHALL have port jaddr  input  26  jump target field.
REQ-013 SHALL have port jr_addr  input  32  register target for jr.
REQ-014 SHALL have port halt  input  1  decoded HALT in ID.
REQ-015 SHALL have port instr_o  output  32  IF/ID instruction.
REQ-016 SHALL have port npc_o  output  32  IF/ID PC+4.
REQ-017 SHALL have port valid_o  output  1  IF/ID holds a live instruction.

Function
REQ-018 SHALL compute redirect = ~stall & valid_o & ((PCSel==00)|(PCSel==10)|(PCSel==01 & branch_taken)).
REQ-019 SHALL compute targets: jump {npc_o[31:28],jaddr,2'b00}; branch npc_o + (sign-extended br_imm << 2); jr jr_addr.
REQ-020 SHALL apply PC next-state priority: halted > stall > redirect > ihit (PC+4) > hold.
REQ-021 SHALL, on redirect, load the target into PC and clear the IF/ID latch (valid_o=0, instr_o=0, npc_o=0) in the same edge; the current imemload is discarded.
REQ-022 SHALL, on ihit with no stall and no redirect, latch instr_o=imemload, npc_o=PC+4, valid_o=1 (1-cycle latency from ihit).
REQ-023 SHALL, with no ihit, no stall and no redirect, set valid_o=0 (bubble) and hold the PC.
REQ-024 SHALL hold instr_o, npc_o and valid_o unchanged while stall=1.
REQ-025 SHALL, on halt & valid_o & ~stall, set a sticky halted flag; once set, iREN=0, the PC is frozen and valid_o=0 from the next edge.
REQ-026 SHALL drive iREN = ~halted.
REQ-027 SHALL wrap PC arithmetic modulo 2^32 with no overflow detection.

Reset
REQ-028 SHALL, while RST=1, asynchronously force PC=PC_INIT, instr_o=0, npc_o=0, valid_o=0, halted=0 and the skid buffer to empty.
REQ-029 SHALL, on RST asserted mid-miss or mid-stall, abandon all in-flight state; the first fetch after release is at PC_INIT.

Configuration
REQ-030 SHALL compile a one-entry skid buffer when macro FETCH_SKID_EN is defined.
REQ-031 SHALL, with FETCH_SKID_EN defined: when ihit & stall and the buffer is empty, capture imemload/PC+4 and advance the PC; when the buffer is full, hold the PC; on stall release, fill IF/ID from the buffer (not imemload) and empty it; redirect empties it.
REQ-032 SHALL, without FETCH_SKID_EN, ignore ihit while stalled and refetch the same PC after release.

Structure
REQ-033 SHALL take word_t and a pcsel_t enum (PC_JUMP=2'b00, PC_BRANCH=2'b01, PC_JR=2'b10, PC_SEQ=2'b11) from cpu_types_pkg.
REQ-034 SHALL place target selection in combinational sub-module pc_next_calc; the registers, halt flag and skid buffer stay in fetch_stage.

Verification
REQ-035 SHALL test reset/sequential fetch: RST pulse, ihit=1 every cycle, imemload=32'h2001_0005 -> imemaddr 0,4,8; instr_o=32'h2001_0005, npc_o=4 one cycle after the first ihit.
REQ-036 SHALL test branch taken: valid_o=1, npc_o=32'h0000_0010, PCSel=01, branch_taken=1, br_imm=16'hFFFE -> next PC=32'h0000_0008, valid_o=0.
REQ-037 SHALL test jump versus stall: PCSel=00, jaddr=26'h0000040, stall=1 for 2 cycles -> PC and IF/ID hold; PC=32'h0000_0100 on the first unstalled edge.
REQ-038 SHALL test halt: halt=1 with valid_o=1 -> iREN=0 next cycle and the PC stays constant for 10 cycles despite ihit=1.
REQ-039 SHALL test icache miss: ihit=0 for 3 cycles at PC 32'h0000_0020 -> valid_o=0 each cycle, imemaddr stable at 32'h20.
REQ-040 SHALL test the skid buffer (FETCH_SKID_EN): ihit=1 during a 1-cycle stall -> PC advances by 4 once; after the stall, instr_o equals the word captured during the stall, with no refetch.
